led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Parametrised LED pattern generator: successor to the fixed 4-LED shift/speed block on the board top level. A free-running prescaler with four selectable limits produces a step tick. Each tick advances an NB_LEDS-wide pattern in one of four modes: rotate left, rotate right, ping-pong, or flash. The pattern is routed to one or all of three colour channels. The block sits between the switch/button inputs and the RGB LED pins.

## Interface
- NB_LEDS, 4: pattern width, minimum 2
- NB_COUNTER, 32: prescaler width
- R0, 2**23: speed 0 limit in cycles per step
- R1, 2**24: speed 1 limit
- R2, 2**25: speed 2 limit
- R3, 2**26: speed 3 limit
  - All limits are ≥1 and fit in NB_COUNTER bits.
- clock  in  1  system clock; all logic on rising edge
- i_reset  in  1  synchronous reset, active-high
- i_enable  in  1  1 = run; 0 = freeze counter and pattern
- i_speed_sel  in  2  selects R0..R3
- i_mode  in  2  00 rotate left, 01 rotate right, 10 ping-pong, 11 flash
- i_color_sel  in  2  00 red, 01 green, 10 blue, 11 all three
- o_led  out  NB_LEDS  current pattern, ungated
- o_led_r  out  NB_LEDS  red channel
- o_led_g  out  NB_LEDS  green channel
- o_led_b  out  NB_LEDS  blue channel
- o_tick  out  1  one-cycle pulse on every pattern step

## Operation
- Prescaler:
  - cnt increments each cycle while i_enable=1.
  - When cnt ≥ limit−1, the tick fires, cnt clears to 0, and o_tick=1 that cycle.
  - The ≥ comparison makes a speed change to a smaller limit mid-count fire on the next enabled cycle, with no wrap through 2**NB_COUNTER.
  - A limit of 1 gives a tick every enabled cycle.
- Enable low: cnt, pattern and direction hold; o_tick=0.
- Mode register mode_q:
  - When i_mode ≠ mode_q, regardless of i_enable, that cycle loads mode_q ← i_mode, cnt ← 0 and the mode's seed pattern; dir ← up.
  - No tick occurs in a reload cycle.
- Seed patterns: modes 00/01/10 seed to 0…01; mode 11 seeds to all ones.
- Step behaviour on each tick:
  - 00: rotate left, MSB wraps to LSB.
  - 01: rotate right, LSB wraps to MSB.
  - 10 (ping-pong):
    - dir up: if pattern[NB_LEDS−1]=1, set dir down and shift right; else shift left.
    - dir down: if pattern[0]=1, set dir up and shift left; else shift right.
    - Period is 2·(NB_LEDS−1) ticks; the end LEDs are never held for two ticks.
  - 11: pattern ← ~pattern, so all-on and all-off alternate.
- Colour:
  - i_color_sel is registered into color_q every cycle, independent of enable.
  - o_led_x = pattern when color_q selects x or color_q=11; otherwise 0.
- o_led always equals pattern.

## Timing
- Reset values (cycle after i_reset sampled high):
  - cnt=0, pattern=0…01, dir=up, mode_q=00, color_q=00, o_tick=0.
  - Therefore o_led=0…01, o_led_r=0…01, o_led_g=0, o_led_b=0.
- Reset has priority over enable, mode reload and tick.
- If i_mode≠00 at reset release, a reload occurs on the first post-reset cycle.
- Step rate: with i_enable held high, o_tick period is exactly limit cycles. The first tick after reset or reload comes limit cycles after cnt clears.
- Pattern, o_led and colour outputs change on the same edge that o_tick is high; no extra latency.
- Colour change appears on the outputs one cycle after i_color_sel changes.
- Mode change is visible on o_led one cycle after i_mode changes.
- Mode change coinciding with a tick: the reload wins and no step is applied.
- Enable drop on a would-be tick cycle: no tick; the count resumes from the held value.

## Test plan
Benches override R0=4, R1=8, R2=16, R3=32, NB_LEDS=4.
- Reset, enable=1, mode 00, speed 0 -> o_tick every 4 cycles; o_led sequence 0001, 0010, 0100, 1000, 0001; only o_led_r active.
- Mode 01, then mode 10 -> mode 01 gives 0001, 1000, 0100; mode 10 gives 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010 (period 6 ticks).
- Mode 11, colour 11 -> o_led_r, o_led_g and o_led_b all show 1111 then 0000, alternating every tick.
- Speed 3 running with cnt≈20, switch to speed 0 -> tick on the next cycle; thereafter every 4 cycles.
- Enable low for 50 cycles mid-count -> pattern frozen, no o_tick; on re-enable the remaining count completes without restart.
- i_reset asserted mid ping-pong with dir=down -> next cycle o_led=0001, dir up, cnt=0. Mode change on a tick cycle -> seed loaded, no step.

Source files
------------

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled LED pattern stepper with rotate,
// ping-pong and flash modes, routed to one or all RGB channels.
module led_pattern_gen #(
    parameter int          NB_LEDS    = 4,
    parameter int          NB_COUNTER = 32,
    parameter int unsigned R0         = 2**23,
    parameter int unsigned R1         = 2**24,
    parameter int unsigned R2         = 2**25,
    parameter int unsigned R3         = 2**26
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [1:0]         i_speed_sel,
    input  logic [1:0]         i_mode,
    input  logic [1:0]         i_color_sel,
    output logic [NB_LEDS-1:0] o_led,
    output logic [NB_LEDS-1:0] o_led_r,
    output logic [NB_LEDS-1:0] o_led_g,
    output logic [NB_LEDS-1:0] o_led_b,
    output logic               o_tick
);

    typedef enum logic [1:0] {
        MODE_ROL   = 2'b00,
        MODE_ROR   = 2'b01,
        MODE_PING  = 2'b10,
        MODE_FLASH = 2'b11
    } mode_e;

    localparam logic [NB_COUNTER-1:0] LIM0 = NB_COUNTER'(R0 - 1);
    localparam logic [NB_COUNTER-1:0] LIM1 = NB_COUNTER'(R1 - 1);
    localparam logic [NB_COUNTER-1:0] LIM2 = NB_COUNTER'(R2 - 1);
    localparam logic [NB_COUNTER-1:0] LIM3 = NB_COUNTER'(R3 - 1);
    localparam logic [NB_LEDS-1:0]    SEED = NB_LEDS'(1);

    logic [NB_COUNTER-1:0] cnt_q, cnt_d;
    logic [NB_LEDS-1:0]    pat_q, pat_d;
    logic                  dir_q, dir_d;
    mode_e                 mode_q, mode_d;
    logic [1:0]            color_q, color_d;
    logic                  tick_q, tick_d;

    logic [NB_COUNTER-1:0] lim_m1;
    logic [NB_LEDS-1:0]    step_pat;
    logic                  step_dir;

    // select terminal count (limit-1) for the chosen speed
    always_comb begin
        lim_m1 = LIM0;
        case (i_speed_sel)
            2'b00: lim_m1 = LIM0;
            2'b01: lim_m1 = LIM1;
            2'b10: lim_m1 = LIM2;
            2'b11: lim_m1 = LIM3;
        endcase
    end

    // next pattern and direction if a step happens this cycle
    always_comb begin
        step_pat = pat_q;
        step_dir = dir_q;
        case (mode_q)
            MODE_ROL:   step_pat = {pat_q[NB_LEDS-2:0], pat_q[NB_LEDS-1]};
            MODE_ROR:   step_pat = {pat_q[0], pat_q[NB_LEDS-1:1]};
            MODE_PING: begin
                if (!dir_q) begin
                    if (pat_q[NB_LEDS-1]) begin
                        step_dir = 1'b1;
                        step_pat = pat_q >> 1;
                    end else begin
                        step_pat = pat_q << 1;
                    end
                end else begin
                    if (pat_q[0]) begin
                        step_dir = 1'b0;
                        step_pat = pat_q << 1;
                    end else begin
                        step_pat = pat_q >> 1;
                    end
                end
            end
            MODE_FLASH: step_pat = ~pat_q;
        endcase
    end

    // mode reload beats prescaler; enable low freezes everything
    always_comb begin
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        color_d = i_color_sel;
        if (i_mode != mode_q) begin
            mode_d = mode_e'(i_mode);
            cnt_d  = '0;
            dir_d  = 1'b0;
            pat_d  = (i_mode == MODE_FLASH) ? '1 : SEED;
        end else if (i_enable) begin
            if (cnt_q >= lim_m1) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                pat_d  = step_pat;
                dir_d  = step_dir;
            end else begin
                cnt_d = cnt_q + NB_COUNTER'(1);
            end
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clock) begin
        if (i_reset) begin
            cnt_q   <= '0;
            pat_q   <= SEED;
            dir_q   <= 1'b0;
            mode_q  <= MODE_ROL;
            color_q <= 2'b00;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            color_q <= color_d;
            tick_q  <= tick_d;
        end
    end

    // channel routing from registered colour select
    always_comb begin
        o_led   = pat_q;
        o_tick  = tick_q;
        o_led_r = (color_q == 2'b00 || color_q == 2'b11) ? pat_q : '0;
        o_led_g = (color_q == 2'b01 || color_q == 2'b11) ? pat_q : '0;
        o_led_b = (color_q == 2'b10 || color_q == 2'b11) ? pat_q : '0;
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: expected tick records are
// queued by the stimulus and popped by a monitor on each o_tick.
module tb_led_pattern_gen;

    logic       clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_enable = 1'b1;
    logic [1:0] i_speed_sel = 2'b00;
    logic [1:0] i_mode = 2'b00;
    logic [1:0] i_color_sel = 2'b00;
    logic [3:0] o_led, o_led_r, o_led_g, o_led_b;
    logic       o_tick;

    typedef struct {
        int         stamp;
        logic [3:0] led;
        logic [1:0] col;
    } rec_t;

    rec_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    led_pattern_gen #(
        .NB_LEDS(4), .NB_COUNTER(32),
        .R0(4), .R1(8), .R2(16), .R3(32)
    ) dut (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable),
        .i_speed_sel(i_speed_sel), .i_mode(i_mode),
        .i_color_sel(i_color_sel), .o_led(o_led), .o_led_r(o_led_r),
        .o_led_g(o_led_g), .o_led_b(o_led_b), .o_tick(o_tick)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, want);
        end
    endtask

    task automatic exp_tick(int stamp, logic [3:0] led, logic [1:0] col);
        rec_t r;
        r.stamp = stamp;
        r.led   = led;
        r.col   = col;
        q.push_back(r);
    endtask

    task automatic wait_cyc(int t);
        while (cyc < t) @(negedge clock);
    endtask

    // monitor: every tick must match the oldest queued record
    always @(negedge clock) begin
        if (o_tick === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_tick", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                rec_t r;
                logic [3:0] er, eg, eb;
                r  = q.pop_front();
                er = (r.col == 2'b00 || r.col == 2'b11) ? r.led : 4'b0;
                eg = (r.col == 2'b01 || r.col == 2'b11) ? r.led : 4'b0;
                eb = (r.col == 2'b10 || r.col == 2'b11) ? r.led : 4'b0;
                chk("tick_time", 32'(cyc), 32'(r.stamp));
                chk("tick_led", 32'(o_led), 32'(r.led));
                chk("tick_r", 32'(o_led_r), 32'(er));
                chk("tick_g", 32'(o_led_g), 32'(eg));
                chk("tick_b", 32'(o_led_b), 32'(eb));
            end
        end
    end

    initial begin
        int e, m, p, f, g, h, r;
        @(negedge clock);
        e = cyc;
        chk("rst_led", 32'(o_led), 32'h1);
        chk("rst_r", 32'(o_led_r), 32'h1);
        chk("rst_g", 32'(o_led_g), 32'h0);
        chk("rst_b", 32'(o_led_b), 32'h0);
        chk("rst_tick", 32'(o_tick), 32'h0);
        i_reset = 1'b0;
        exp_tick(e + 4, 4'b0010, 2'b00);
        exp_tick(e + 8, 4'b0100, 2'b00);
        exp_tick(e + 12, 4'b1000, 2'b00);
        exp_tick(e + 16, 4'b0001, 2'b00);
        wait_cyc(e + 16);

        i_mode = 2'b01;
        @(negedge clock);
        m = cyc;
        chk("ror_seed", 32'(o_led), 32'h1);
        exp_tick(m + 4, 4'b1000, 2'b00);
        exp_tick(m + 8, 4'b0100, 2'b00);
        wait_cyc(m + 8);

        i_mode = 2'b10;
        @(negedge clock);
        p = cyc;
        chk("ping_seed", 32'(o_led), 32'h1);
        exp_tick(p + 4, 4'b0010, 2'b00);
        exp_tick(p + 8, 4'b0100, 2'b00);
        exp_tick(p + 12, 4'b1000, 2'b00);
        exp_tick(p + 16, 4'b0100, 2'b00);
        exp_tick(p + 20, 4'b0010, 2'b00);
        exp_tick(p + 24, 4'b0001, 2'b00);
        exp_tick(p + 28, 4'b0010, 2'b00);
        wait_cyc(p + 28);

        i_mode = 2'b11;
        i_color_sel = 2'b11;
        @(negedge clock);
        f = cyc;
        chk("flash_r", 32'(o_led_r), 32'hF);
        chk("flash_g", 32'(o_led_g), 32'hF);
        chk("flash_b", 32'(o_led_b), 32'hF);
        exp_tick(f + 4, 4'b0000, 2'b11);
        exp_tick(f + 8, 4'b1111, 2'b11);
        exp_tick(f + 12, 4'b0000, 2'b11);
        wait_cyc(f + 12);

        i_speed_sel = 2'b11;
        wait_cyc(f + 32);
        i_speed_sel = 2'b00;
        exp_tick(f + 33, 4'b1111, 2'b11);
        exp_tick(f + 37, 4'b0000, 2'b11);
        exp_tick(f + 41, 4'b1111, 2'b11);
        wait_cyc(f + 41);

        g = f + 41;
        wait_cyc(g + 2);
        i_enable = 1'b0;
        wait_cyc(g + 52);
        chk("freeze_led", 32'(o_led), 32'hF);
        i_enable = 1'b1;
        exp_tick(g + 54, 4'b0000, 2'b11);
        exp_tick(g + 58, 4'b1111, 2'b11);
        wait_cyc(g + 58);
        i_color_sel = 2'b01;
        @(negedge clock);
        chk("col_r", 32'(o_led_r), 32'h0);
        chk("col_g", 32'(o_led_g), 32'hF);
        chk("col_b", 32'(o_led_b), 32'h0);
        exp_tick(g + 62, 4'b0000, 2'b01);
        wait_cyc(g + 65);
        i_mode = 2'b00;
        @(negedge clock);
        chk("tick_reload_led", 32'(o_led), 32'h1);
        chk("tick_reload_g", 32'(o_led_g), 32'h1);
        chk("tick_reload_tick", 32'(o_tick), 32'h0);
        exp_tick(g + 70, 4'b0010, 2'b01);
        wait_cyc(g + 70);

        i_mode = 2'b10;
        i_color_sel = 2'b00;
        @(negedge clock);
        h = cyc;
        exp_tick(h + 4, 4'b0010, 2'b00);
        exp_tick(h + 8, 4'b0100, 2'b00);
        exp_tick(h + 12, 4'b1000, 2'b00);
        exp_tick(h + 16, 4'b0100, 2'b00);
        exp_tick(h + 20, 4'b0010, 2'b00);
        wait_cyc(h + 22);
        i_reset = 1'b1;
        @(negedge clock);
        r = cyc;
        chk("mid_rst_led", 32'(o_led), 32'h1);
        chk("mid_rst_r", 32'(o_led_r), 32'h1);
        chk("mid_rst_tick", 32'(o_tick), 32'h0);
        i_reset = 1'b0;
        exp_tick(r + 5, 4'b0010, 2'b00);
        exp_tick(r + 9, 4'b0100, 2'b00);
        @(negedge clock);
        chk("post_rst_reload", 32'(o_led), 32'h1);
        wait_cyc(r + 11);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
